// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - program load, run and fetch signals between control unit and instr_fetch
interface instr_fetch_if #(
  parameter int AW = 3,
  parameter int IW = 16
);
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic          run;
  logic [AW-1:0] pc_addr;
  logic [IW-1:0] ir;
  logic          instr_valid;
  logic          run_valid;
  logic          done;
  logic [AW:0]   prog_len;
  logic          ld_err;
  logic          par_err;

  modport master (
    output ld_en, ld_addr, ld_data, run, pc_addr,
    input  ir, instr_valid, run_valid, done, prog_len, ld_err, par_err
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, run, pc_addr,
    output ir, instr_valid, run_valid, done, prog_len, ld_err, par_err
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: loadable program memory, refetch on pc_addr change
// Optional even-parity protection of the program memory is enabled by defining IFETCH_PARITY_EN.
module instr_fetch #(
  parameter int AW = 3,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

`ifdef IFETCH_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          instr_valid_q, instr_valid_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          ld_err_q, ld_err_d;
  logic          par_err_q, par_err_d;
  logic [AW-1:0] last_pc_q, last_pc_d;

  logic [MW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] rd_word;
  logic          rd_bad;
  logic [AW:0]   ld_end;
  logic [AW:0]   pc_ext;
  logic          run_ok;

  assign rd_word = mem_q[bus.pc_addr];
  assign ld_end  = {1'b0, bus.ld_addr} + {{AW{1'b0}}, 1'b1};
  assign pc_ext  = {1'b0, bus.pc_addr};
  assign run_ok  = bus.run && (prog_len_q != '0) && !par_err_q;

`ifdef IFETCH_PARITY_EN
  // Stored word plus its parity bit always XORs to zero when intact.
  assign mem_wdata = {^bus.ld_data, bus.ld_data};
  assign rd_bad    = ^rd_word;
`else
  assign mem_wdata = bus.ld_data;
  assign rd_bad    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    prog_len_d    = prog_len_q;
    ld_err_d      = 1'b0;
    par_err_d     = par_err_q;
    last_pc_d     = last_pc_q;
    mem_we        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        instr_valid_d = 1'b0;
        if (bus.ld_en) begin
          mem_we = 1'b1;
          if (ld_end > prog_len_q) prog_len_d = ld_end;
        end else if (run_ok) begin
          if (pc_ext >= prog_len_q) begin
            state_d = DONE;
          end else begin
            state_d   = FETCH;
            last_pc_d = bus.pc_addr;
          end
        end
      end
      FETCH: begin
        ld_err_d  = bus.ld_en;
        last_pc_d = bus.pc_addr;
        if (rd_bad) begin
          par_err_d     = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = DONE;
        end else begin
          ir_d          = rd_word[IW-1:0];
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        ld_err_d = bus.ld_en;
        if (bus.pc_addr != last_pc_q) begin
          instr_valid_d = 1'b0;
          // A wrap back to address 0 means the program ran off its end.
          if (bus.pc_addr == '0 || pc_ext >= prog_len_q) state_d = DONE;
          else                                           state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ir_q          <= '0;
      instr_valid_q <= 1'b0;
      prog_len_q    <= '0;
      ld_err_q      <= 1'b0;
      par_err_q     <= 1'b0;
      last_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
      prog_len_q    <= prog_len_d;
      ld_err_q      <= ld_err_d;
      par_err_q     <= par_err_d;
      last_pc_q     <= last_pc_d;
    end
  end

  // Program memory is intentionally left out of reset so a program can be re-run.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bus.ld_addr] <= mem_wdata;
  end

  assign bus.ir          = ir_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.run_valid   = (state_q == FETCH) || (state_q == HOLD);
  assign bus.done        = (state_q == DONE);
  assign bus.prog_len    = prog_len_q;
  assign bus.ld_err      = ld_err_q;
  assign bus.par_err     = par_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed plus randomized checks of instr_fetch against a memory/length model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [15:0] mm [8];
  int          mlen = 0;
  bit          running;
  int          cur;
  int          np;

  instr_fetch_if #(.AW(3), .IW(16)) bus ();

  instr_fetch #(.AW(3), .IW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [15:0] d, input bit accept);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'(a);
    bus.ld_data = d;
    tick();
    bus.ld_en = 1'b0;
    if (accept) begin
      mm[a] = d;
      if (a + 1 > mlen) mlen = a + 1;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ir",        32'(bus.ir), 32'h0);
    chk("rst_valid",     32'(bus.instr_valid), 32'h0);
    chk("rst_run_valid", 32'(bus.run_valid), 32'h0);
    chk("rst_done",      32'(bus.done), 32'h0);
    chk("rst_ld_err",    32'(bus.ld_err), 32'h0);
    chk("rst_prog_len",  32'(bus.prog_len), 32'h0);
    chk("rst_par_err",   32'(bus.par_err), 32'h0);
  endtask

  initial begin
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.run = 1'b0; bus.pc_addr = '0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs();

    // Short program, start and step
    load(0, 16'h0048, 1'b1);
    load(1, 16'h0091, 1'b1);
    load(2, 16'h00C0, 1'b1);
    chk("prog_len3", 32'(bus.prog_len), 32'(mlen));
    bus.pc_addr = 3'd0;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk("start_run_valid", 32'(bus.run_valid), 32'h1);
    chk("start_gap", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("start_ir", 32'(bus.ir), 32'h0048);
    chk("start_valid", 32'(bus.instr_valid), 32'h1);
    for (int p = 1; p < 3; p++) begin
      bus.pc_addr = 3'(p);
      tick();
      chk("step_gap", 32'(bus.instr_valid), 32'h0);
      chk("step_run_valid", 32'(bus.run_valid), 32'h1);
      tick();
      chk("step_ir", 32'(bus.ir), 32'(mm[p]));
      chk("step_valid", 32'(bus.instr_valid), 32'h1);
    end
    bus.pc_addr = 3'd3;
    tick();
    chk("end_done", 32'(bus.done), 32'h1);
    chk("end_run_valid", 32'(bus.run_valid), 32'h0);
    chk("end_valid", 32'(bus.instr_valid), 32'h0);

    // Full 8-word program walked to wrap
    for (int a = 0; a < 8; a++) load(a, 16'($urandom) & 16'h7FFF, 1'b1);
    chk("prog_len8", 32'(bus.prog_len), 32'(mlen));
    bus.pc_addr = 3'd0;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    chk("full_ir0", 32'(bus.ir), 32'(mm[0]));
    for (int p = 1; p < 8; p++) begin
      bus.pc_addr = 3'(p);
      tick();
      chk("full_gap", 32'(bus.instr_valid), 32'h0);
      tick();
      chk("full_ir", 32'(bus.ir), 32'(mm[p]));
    end
    bus.pc_addr = 3'd0;
    tick();
    chk("wrap_done", 32'(bus.done), 32'h1);
    chk("wrap_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("wrap_no_refetch", 32'(bus.ir), 32'(mm[7]));

    // Load rejected while a program runs
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    load(5, 16'hFFFF, 1'b0);
    chk("ld_err_pulse", 32'(bus.ld_err), 32'h1);
    tick();
    chk("ld_err_clear", 32'(bus.ld_err), 32'h0);
    chk("ld_err_prog_len", 32'(bus.prog_len), 32'(mlen));
    bus.pc_addr = 3'd5;
    tick();
    tick();
    chk("ld_err_mem5", 32'(bus.ir), 32'(mm[5]));

    // Reset mid-HOLD, then memory survives
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mlen = 0;
    chk_reset_outputs();
    bus.pc_addr = 3'd0;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk("empty_run_ignored", 32'(bus.run_valid), 32'h0);
    chk("empty_run_done", 32'(bus.done), 32'h0);
    bus.run = 1'b1;
    load(0, mm[0], 1'b1);
    bus.run = 1'b0;
    chk("ld_run_prog_len", 32'(bus.prog_len), 32'(mlen));
    chk("ld_run_idle", 32'(bus.run_valid), 32'h0);
    chk("ld_run_not_done", 32'(bus.done), 32'h0);
    load(3, mm[3], 1'b1);
    chk("reload_prog_len", 32'(bus.prog_len), 32'h4);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    chk("rerun_ir0", 32'(bus.ir), 32'(mm[0]));
    bus.pc_addr = 3'd2;
    tick();
    tick();
    chk("rerun_old_mem2", 32'(bus.ir), 32'(mm[2]));
    running = 1'b1;
    cur = 2;

    // Random pc walks against the model
    for (int it = 0; it < 60; it++) begin
      if (!running) begin
        np = int'($urandom_range(0, 7));
        bus.pc_addr = 3'(np);
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        if (np >= mlen) begin
          chk("rnd_start_done", 32'(bus.done), 32'h1);
          chk("rnd_start_rv", 32'(bus.run_valid), 32'h0);
        end else begin
          chk("rnd_start_rv", 32'(bus.run_valid), 32'h1);
          tick();
          chk("rnd_start_ir", 32'(bus.ir), 32'(mm[np]));
          chk("rnd_start_valid", 32'(bus.instr_valid), 32'h1);
          running = 1'b1;
          cur = np;
        end
      end else begin
        np = int'($urandom_range(0, 7));
        bus.pc_addr = 3'(np);
        tick();
        if (np == cur) begin
          chk("rnd_hold_valid", 32'(bus.instr_valid), 32'h1);
          chk("rnd_hold_ir", 32'(bus.ir), 32'(mm[cur]));
        end else if (np == 0 || np >= mlen) begin
          chk("rnd_done", 32'(bus.done), 32'h1);
          chk("rnd_done_valid", 32'(bus.instr_valid), 32'h0);
          running = 1'b0;
        end else begin
          chk("rnd_gap", 32'(bus.instr_valid), 32'h0);
          tick();
          chk("rnd_ir", 32'(bus.ir), 32'(mm[np]));
          chk("rnd_valid", 32'(bus.instr_valid), 32'h1);
          cur = np;
        end
      end
      if (it == 30 && !running) begin
        np = int'($urandom_range(0, 7));
        load(np, mm[np], 1'b1);
        chk("rnd_prog_len", 32'(bus.prog_len), 32'(mlen));
      end
    end

`ifdef IFETCH_PARITY_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mlen = 0;
    load(0, 16'h1234, 1'b1);
    load(1, 16'h0F0F, 1'b1);
    dut.mem_q[1][16] = ~dut.mem_q[1][16];
    bus.pc_addr = 3'd1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    chk("par_err_set", 32'(bus.par_err), 32'h1);
    chk("par_done", 32'(bus.done), 32'h1);
    chk("par_valid", 32'(bus.instr_valid), 32'h0);
    bus.pc_addr = 3'd0;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk("par_run_ignored", 32'(bus.run_valid), 32'h0);
    chk("par_sticky", 32'(bus.par_err), 32'h1);
`else
    chk("par_err_tied", 32'(bus.par_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the processor control unit. Holds an 8-word × 16-bit program memory loaded over a simple write port. Once started, it returns the word addressed by the control unit's `pc_addr` as `ir` with `instr_valid`, and refetches whenever `pc_addr` changes. It drives the control unit's `valid` input and reports end of program.

## Interface
- `AW`, 3: program address width; must match the control unit `pc_addr` width.
- `IW`, 16: instruction width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_en`  in  1  write strobe for program memory.
- `ld_addr`  in  AW  write address.
- `ld_data`  in  IW  write data.
- `run`  in  1  single-cycle start pulse.
- `pc_addr`  in  AW  program counter from the control unit.
- `ir`  out  IW  registered instruction word.
- `instr_valid`  out  1  `ir` holds `mem[pc_addr]`.
- `run_valid`  out  1  high in FETCH and HOLD; connects to control unit `valid`.
- `done`  out  1  high in DONE.
- `prog_len`  out  AW+1  number of loaded words, 0..8.
- `ld_err`  out  1  one-cycle pulse when a load is rejected.
- `par_err`  out  1  sticky parity fault; see Configuration.

## Operation
- States:
  - IDLE: after reset.
  - FETCH: one-cycle memory read.
  - HOLD: `ir` presented.
  - DONE: program exhausted or fault.
- Loads:
  - Accepted only in IDLE or DONE.
  - On an accepted load, `mem[ld_addr] <= ld_data` and `prog_len <= max(prog_len, ld_addr+1)`.
  - A load in FETCH or HOLD is dropped, and `ld_err` pulses on the next cycle.
- IDLE/DONE + `run`:
  - If `prog_len == 0`, `run` is ignored.
  - If `pc_addr >= prog_len`, go to DONE.
  - Otherwise go to FETCH and capture `last_pc <= pc_addr`.
  - If `ld_en` and `run` arrive in the same cycle, the load is performed and `run` is ignored.
- FETCH: `ir <= mem[pc_addr]`, `last_pc <= pc_addr`, `instr_valid <= 1`, go to HOLD.
- HOLD:
  - While `pc_addr == last_pc`: stay, with `ir` and `instr_valid` stable.
  - When `pc_addr != last_pc`:
    - If `pc_addr == 0` (wrap 7→0) or `pc_addr >= prog_len`: go to DONE with `instr_valid <= 0`.
    - Otherwise: go to FETCH with `instr_valid <= 0`.
- DONE: `done = 1`, `run_valid = 0`, `instr_valid = 0`. `ir` keeps its last value.
- Memory is not cleared by reset. Contents survive a reset for re-run.
- `rst` at any time, including mid-FETCH or mid-HOLD:
  - Go to IDLE.
  - `ir = 0`, `instr_valid = 0`, `run_valid = 0`, `done = 0`, `ld_err = 0`, `prog_len = 0`, `par_err = 0`, `last_pc = 0`.

## Timing
- Start: `run` sampled at edge t → FETCH in cycle t+1 (`run_valid = 1`) → `ir`/`instr_valid` valid from t+2.
- PC change: `pc_addr` changes before edge t → `instr_valid` = 0 in cycle t+1 (FETCH) → new `ir` with `instr_valid = 1` from t+2. Refetch latency is 2 cycles.
- `pc_addr` changes while in FETCH are picked up: the value read is `mem[pc_addr]` sampled at the FETCH edge, and `last_pc` tracks it.
- Memory read is synchronous, one cycle. There is no combinational path from `pc_addr` to `ir`.
- `ld_err` is registered and asserts the cycle after the rejected `ld_en`.
- `done` asserts the cycle after the terminating `pc_addr` change.

## Configuration
- `IFETCH_PARITY_EN` defined:
  - Memory is IW+1 bits wide, storing even parity of `ld_data` on each load.
  - FETCH checks parity. On mismatch:
    - `instr_valid` stays 0.
    - `par_err` sets (sticky until `rst`).
    - The state goes to DONE.
  - `run` is ignored while `par_err = 1`.
- `IFETCH_PARITY_EN` undefined: memory is IW bits and `par_err` is tied 0. Ports are identical in both builds.

## Test plan
- Reset, load addr 0..2 with 16'h0048, 16'h0091, 16'h00C0, `pc_addr = 0`, pulse `run` → `prog_len = 3`; `ir = 16'h0048` with `instr_valid = 1` two cycles after `run`; `run_valid = 1` from the next cycle.
- In HOLD, step `pc_addr` 0→1→2→3 → `ir` = 16'h0091 then 16'h00C0, each with one `instr_valid = 0` gap cycle; `pc_addr = 3` → `done = 1`, `run_valid = 0`.
- Load all 8 words, run, walk `pc_addr` 0..7 then wrap to 0 → DONE on wrap; no refetch of word 0.
- Assert `ld_en` (addr 5, 16'hFFFF) during HOLD → `ld_err` pulses 1 cycle, `mem[5]` unchanged, `prog_len` unchanged. Assert `ld_en` and `run` together in IDLE → load done, state stays IDLE.
- Assert `rst` mid-HOLD → next cycle all outputs 0 and IDLE. Reload `prog_len` (load addr 0 with the same data), run → old `mem` contents returned for the unwritten addresses.
- With `IFETCH_PARITY_EN`, force a parity bit flip in `mem[1]` and fetch `pc_addr = 1` → `par_err = 1`, `done = 1`, `instr_valid = 0`; a subsequent `run` is ignored.
